// File: rtl/ftdi_tx_arbiter_if.sv
// rtl/ftdi_tx_arbiter_if.sv - requester and Tx FIFO write-side bundle of the FTDI Tx arbiter
interface ftdi_tx_arbiter_if #(
  parameter int pNumReq = 4
);
  logic [pNumReq-1:0]   iReqValid;
  logic [8*pNumReq-1:0] iReqLen;
  logic [8*pNumReq-1:0] iReqData;
  logic [pNumReq-1:0]   oReqReady;
  logic [pNumReq-1:0]   oGrant;
  logic                 oTxEn;
  logic [7:0]           oTxData;
  logic                 iTxFull;
  logic                 oBusy;

  // master: requesters plus FIFO side; slave: the arbiter itself
  modport master (
    output iReqValid, iReqLen, iReqData, iTxFull,
    input  oReqReady, oGrant, oTxEn, oTxData, oBusy
  );

  modport slave (
    input  iReqValid, iReqLen, iReqData, iTxFull,
    output oReqReady, oGrant, oTxEn, oTxData, oBusy
  );
endinterface

// File: rtl/ftdi_tx_arbiter.sv
// rtl/ftdi_tx_arbiter.sv - round-robin packet framer sharing the FTDI Tx FIFO write port
module ftdi_tx_arbiter #(
  parameter int         pNumReq = 4,
  parameter logic [7:0] pSync   = 8'hA5
) (
  input logic              iClk,
  input logic              iRst_n,
  ftdi_tx_arbiter_if.slave bus
);
  localparam int W = $clog2(pNumReq);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_CHAN, S_LEN, S_DATA, S_CSUM
  } state_t;

  state_t             state_q, state_d;
  logic [pNumReq-1:0] grant_q, grant_d;
  logic [W-1:0]       own_q, own_d;
  logic [W-1:0]       ptr_q, ptr_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [7:0]         csum_q, csum_d;

  logic               found;
  logic [W-1:0]       sel;
  logic [W-1:0]       jw;
  int                 j;
  logic               tx_en;
  logic [7:0]         tx_data;
  logic [7:0]         chan_byte;
  logic [7:0]         owner_data;
  logic [7:0]         sel_len;
  logic [pNumReq-1:0] ready;

  // First valid requester at or above the pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    j     = 0;
    jw    = '0;
    for (int i = 0; i < pNumReq; i++) begin
      j = int'(ptr_q) + i;
      if (j >= pNumReq) j = j - pNumReq;
      jw = W'(j);
      if (!found && bus.iReqValid[jw]) begin
        found = 1'b1;
        sel   = jw;
      end
    end
  end

  assign chan_byte  = 8'(own_q);
  assign owner_data = bus.iReqData[{own_q, 3'b000} +: 8];
  assign sel_len    = bus.iReqLen[{sel, 3'b000} +: 8];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    tx_en   = 1'b0;
    tx_data = 8'h00;
    ready   = '0;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d      = '0;
          grant_d[sel] = 1'b1;
          own_d        = sel;
          cnt_d        = sel_len;
          csum_d       = 8'h00;
          state_d      = S_SYNC;
        end
      end
      S_SYNC: begin
        tx_data = pSync;
        tx_en   = !bus.iTxFull;
        if (tx_en) state_d = S_CHAN;
      end
      S_CHAN: begin
        tx_data = chan_byte;
        tx_en   = !bus.iTxFull;
        if (tx_en) begin
          csum_d  = csum_q ^ chan_byte;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        tx_data = cnt_q;
        tx_en   = !bus.iTxFull;
        if (tx_en) begin
          csum_d  = csum_q ^ cnt_q;
          state_d = (cnt_q != 8'd0) ? S_DATA : S_CSUM;
        end
      end
      S_DATA: begin
        // An owner without a byte simply stalls the packet; there is no timeout.
        tx_data      = owner_data;
        tx_en        = !bus.iTxFull && bus.iReqValid[own_q];
        ready[own_q] = tx_en;
        if (tx_en) begin
          csum_d = csum_q ^ owner_data;
          cnt_d  = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        tx_data = csum_q;
        tx_en   = !bus.iTxFull;
        if (tx_en) begin
          ptr_d   = (own_q == W'(pNumReq - 1)) ? '0 : own_q + W'(1);
          grant_d = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      own_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= 8'h00;
      csum_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
    end
  end

  assign bus.oTxEn     = tx_en;
  assign bus.oTxData   = tx_data;
  assign bus.oReqReady = ready;
  assign bus.oGrant    = grant_q;
  assign bus.oBusy     = (state_q != S_IDLE);
endmodule
